number_classifier: RTL and testbench

- Parametrised, handshaked successor to the fixed-32-bit Fibonacci/palindrome/odd analyzer set.
- Captures a WIDTH-bit operand on `start` and runs an iterative Fibonacci search FSM. Also reports bit-palindrome, odd and power-of-two flags, plus the Fibonacci index when the operand matches.
- Results are registered and qualified by a one-cycle `done` pulse, so one instance replaces the three separate analyzers in the top level.

---
 rtl/number_classifier.sv | 108 ++++++++++
 tb/tb_number_classifier.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/number_classifier.sv
// Operand classifier: iterative Fibonacci search plus palindrome, odd and
// power-of-two flags, all latched together and qualified by a done pulse.
module number_classifier #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  output logic             busy,
  output logic             done,
  output logic             o_fibo,
  output logic [IDX_W-1:0] fibo_index,
  output logic             o_pal,
  output logic             o_odd,
  output logic             o_pow2
);

  localparam int unsigned FW = WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [FW-1:0]    f_prev_q;
  logic [FW-1:0]    f_cur_q;
  logic [IDX_W-1:0] k_q;

  logic [FW-1:0]    f_sum_d;
  logic [WIDTH-1:0] a_rev_c;
  logic             zero_c;
  logic             hit_c;
  logic             over_c;
  logic             pal_c;
  logic             pow2_c;

  // Per-cycle comparison and operand flags derived from the captured operand.
  always_comb begin
    a_rev_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      a_rev_c[i] = a_q[WIDTH-1-i];
    end
    f_sum_d = f_prev_q + f_cur_q;
    zero_c  = (a_q == '0);
    hit_c   = (f_cur_q == {1'b0, a_q});
    over_c  = (f_cur_q > {1'b0, a_q});
    pal_c   = (a_q == a_rev_c);
    pow2_c  = !zero_c && ((a_q & (a_q - WIDTH'(1))) == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      f_prev_q   <= '0;
      f_cur_q    <= '0;
      k_q        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      o_fibo     <= 1'b0;
      fibo_index <= '0;
      o_pal      <= 1'b0;
      o_odd      <= 1'b0;
      o_pow2     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q      <= A;
            f_prev_q <= '0;
            f_cur_q  <= FW'(1);
            k_q      <= IDX_W'(1);
            busy     <= 1'b1;
            state_q  <= S_SCAN;
          end
        end
        S_SCAN: begin
          // Zero has priority, then exact hit, then overshoot; else step the sequence.
          if (zero_c || hit_c || over_c) begin
            o_fibo     <= zero_c || hit_c;
            fibo_index <= (!zero_c && hit_c) ? k_q : '0;
            o_pal      <= pal_c;
            o_odd      <= a_q[0];
            o_pow2     <= pow2_c;
            state_q    <= S_DONE;
          end else begin
            f_prev_q <= f_cur_q;
            f_cur_q  <= f_sum_d;
            k_q      <= k_q + IDX_W'(1);
          end
        end
        S_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_number_classifier.sv
// Scoreboarded random and directed bench for number_classifier at WIDTH=32 and WIDTH=8.
module tb_number_classifier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32, st32, busy32, done32, fibo32, pal32, odd32, pow32;
  logic [31:0] a32;
  logic [7:0]  idx32;
  logic        rst8, st8, busy8, done8, fibo8, pal8, odd8, pow8;
  logic [7:0]  a8;
  logic [7:0]  idx8;

  number_classifier #(.WIDTH(32), .IDX_W(8)) dut32 (
    .clock(clk), .reset(rst32), .start(st32), .A(a32), .busy(busy32), .done(done32),
    .o_fibo(fibo32), .fibo_index(idx32), .o_pal(pal32), .o_odd(odd32), .o_pow2(pow32));

  number_classifier #(.WIDTH(8), .IDX_W(8)) dut8 (
    .clock(clk), .reset(rst8), .start(st8), .A(a8), .busy(busy8), .done(done8),
    .o_fibo(fibo8), .fibo_index(idx8), .o_pal(pal8), .o_odd(odd8), .o_pow2(pow8));

  typedef struct {
    logic [63:0] a;
    bit          fibo;
    int          idx;
    bit          pal;
    bit          odd;
    bit          pow2;
    int          dcyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  longint unsigned fib[0:60];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: table lookup over the Fibonacci sequence plus direct bit rules.
  function automatic exp_t model(input logic [63:0] a, input int w, input int acc);
    exp_t m;
    int k = 0;
    while (fib[k] < a) k++;
    m.a    = a;
    m.fibo = (fib[k] == a);
    m.idx  = m.fibo ? k : 0;
    m.dcyc = acc + ((k == 0) ? 1 : k) + 1;
    m.pal  = 1'b1;
    for (int i = 0; i < w; i++)
      if (a[i] != a[w-1-i]) m.pal = 1'b0;
    m.odd  = a[0];
    m.pow2 = ($countones(a) == 1);
    return m;
  endfunction

  always @(negedge clk) begin : mon32
    exp_t e;
    if (done32) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL done32_unexpected at cycle %0d: got done=1 expected 0", cyc);
      end else begin
        e = q32.pop_front();
        chk("done32_cycle", cyc, e.dcyc);
        chk("fibo32", fibo32, e.fibo);
        chk("idx32", idx32, e.idx);
        chk("pal32", pal32, e.pal);
        chk("odd32", odd32, e.odd);
        chk("pow2_32", pow32, e.pow2);
        chk("busy32_at_done", busy32, 0);
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL done8_unexpected at cycle %0d: got done=1 expected 0", cyc);
      end else begin
        e = q8.pop_front();
        chk("done8_cycle", cyc, e.dcyc);
        chk("fibo8", fibo8, e.fibo);
        chk("idx8", idx8, e.idx);
        chk("pal8", pal8, e.pal);
        chk("odd8", odd8, e.odd);
        chk("pow2_8", pow8, e.pow2);
        chk("busy8_at_done", busy8, 0);
      end
    end
  end

  // Called at a negedge with the DUT idle; the following posedge is the accept edge.
  task automatic issue(input bit is8, input logic [63:0] a, input bit push);
    exp_t e;
    e = model(a, is8 ? 8 : 32, cyc + 1);
    if (is8) begin
      a8 = a[7:0]; st8 = 1'b1;
      if (push) q8.push_back(e);
    end else begin
      a32 = a[31:0]; st32 = 1'b1;
      if (push) q32.push_back(e);
    end
    @(negedge clk);
    st8 = 1'b0; st32 = 1'b0;
    chk(is8 ? "busy8_after_accept" : "busy32_after_accept", is8 ? busy8 : busy32, 1);
  endtask

  task automatic wait_idle(input bit is8);
    for (int i = 0; i < 300; i++) begin
      if ((is8 ? q8.size() : q32.size()) == 0) break;
      @(negedge clk);
    end
    if ((is8 ? q8.size() : q32.size()) != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got pending=%0d expected 0", is8 ? "run8" : "run32",
               is8 ? q8.size() : q32.size());
      if (is8) q8.delete(); else q32.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] v;
    int acc, last_done;
    fib[0] = 0; fib[1] = 1;
    for (int i = 2; i <= 60; i++) fib[i] = fib[i-1] + fib[i-2];
    rst32 = 1'b1; rst8 = 1'b1; st32 = 1'b0; st8 = 1'b0; a32 = '0; a8 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy32", busy32, 0);
    chk("reset_done32", done32, 0);
    chk("reset_fibo32", fibo32, 0);
    chk("reset_idx32", idx32, 0);
    chk("reset_flags32", {pal32, odd32, pow32}, 0);
    chk("reset_busy8", busy8, 0);
    rst32 = 1'b0; rst8 = 1'b0;
    @(negedge clk);

    // Directed operands from the plan
    issue(0, 64'd999610691, 1); wait_idle(0);
    issue(0, 64'd317811, 1);    wait_idle(0);
    issue(0, 64'd2971215073, 1); wait_idle(0);
    issue(0, 64'd0, 1);         wait_idle(0);
    issue(0, 64'd1, 1);         wait_idle(0);
    issue(0, 64'hFFFFFFFF, 1);  wait_idle(0);
    issue(1, 64'd255, 1);       wait_idle(1);
    issue(1, 64'd233, 1);       wait_idle(1);
    issue(1, 64'd128, 1);       wait_idle(1);
    issue(1, 64'd0, 1);         wait_idle(1);

    // Random operands, half drawn from the Fibonacci sequence
    for (int n = 0; n < 30; n++) begin
      v = (n % 2 == 0) ? 64'($urandom) : 64'(fib[$urandom_range(0, 47)]);
      issue(0, v, 1); wait_idle(0);
    end
    for (int n = 0; n < 25; n++) begin
      v = (n % 2 == 0) ? 64'($urandom_range(0, 255)) : 64'(fib[$urandom_range(0, 13)]);
      issue(1, v, 1); wait_idle(1);
    end

    // Start re-pulsed with a different operand mid-search must be ignored
    issue(0, 64'd317811, 1);
    repeat (5) @(negedge clk);
    st32 = 1'b1; a32 = $urandom;
    @(negedge clk);
    st32 = 1'b0;
    a32 = $urandom;
    wait_idle(0);

    // Start held high: back-to-back runs of A=5 (j=5)
    a32 = 32'd5; st32 = 1'b1;
    acc = cyc + 1;
    for (int r = 0; r < 3; r++) begin
      q32.push_back(model(64'd5, 32, acc));
      last_done = acc + 6;
      acc = last_done + 1;
    end
    for (int i = 0; i < 100 && cyc < last_done; i++) @(negedge clk);
    st32 = 1'b0;
    wait_idle(0);

    // Reset ten cycles into a long run: outputs cleared, no done pulse
    issue(0, 64'd999610691, 0);
    repeat (9) @(negedge clk);
    rst32 = 1'b1;
    @(negedge clk);
    chk("midrst_busy32", busy32, 0);
    chk("midrst_done32", done32, 0);
    chk("midrst_fibo32", fibo32, 0);
    chk("midrst_idx32", idx32, 0);
    chk("midrst_flags32", {pal32, odd32, pow32}, 0);
    rst32 = 1'b0;
    repeat (50) @(negedge clk);
    issue(0, 64'd2971215073, 1); wait_idle(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
